// File: rtl/rfile_scb.sv
// -----------------------------------------------------------------------------
// rfile_scb : multi-port register file with per-register pending-write
//             scoreboard.
//
// The issue stage reserves destination registers through the rsv_* ports.
// The writeback stage writes data through the wr_* ports, and each write
// retires one reservation. The read ports return the register value and a
// ready flag that is 1 when no write is pending, so RAW hazards show up
// directly on the read port.
//
// Ports
//   clock, reset_n      rising-edge clock, synchronous active-low reset
//   rd_addr/rd_data/rd_ready [READ_PORTS]  combinational read ports
//   wr_addr/wr_enable/wr_data [WRITE_PORTS] writeback ports; the highest
//                       index wins on an address collision
//   rsv_addr/rsv_enable [RSV_PORTS]         reservation requests
//   rsv_full            combinational; 1 = this cycle's reservations are all
//                       rejected because some counter would overflow
//   flush               clears every pending counter at the edge
//   any_pending         registered; 1 = some counter is nonzero
//
// Build option
//   RFILE_BYPASS_EN     when defined, a same-cycle write is forwarded to the
//                       read ports (data and ready). When undefined, reads
//                       see only registered state.
//
// err_underflow is an internal sticky flag, set when a write retires a
// register that has no pending reservation. Only reset clears it.
// -----------------------------------------------------------------------------
module rfile_scb #(
    parameter int NREGS       = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int READ_PORTS  = 8,
    parameter int WRITE_PORTS = 4,
    parameter int RSV_PORTS   = 2,
    parameter int PEND_WIDTH  = 2,
    parameter int ZERO_REG    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr    [READ_PORTS],
    output logic [DATA_WIDTH-1:0] rd_data    [READ_PORTS],
    output logic                  rd_ready   [READ_PORTS],
    input  logic [ADDR_WIDTH-1:0] wr_addr    [WRITE_PORTS],
    input  logic                  wr_enable  [WRITE_PORTS],
    input  logic [DATA_WIDTH-1:0] wr_data    [WRITE_PORTS],
    input  logic [ADDR_WIDTH-1:0] rsv_addr   [RSV_PORTS],
    input  logic                  rsv_enable [RSV_PORTS],
    output logic                  rsv_full,
    input  logic                  flush,
    output logic                  any_pending
);

    // Width of a per-register reservation count, and of counter arithmetic
    // wide enough to hold cnt + R without wrapping.
    localparam int RC_W  = $clog2(RSV_PORTS + 1);
    localparam int SUM_W = PEND_WIDTH + RC_W + 1;
    localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << PEND_WIDTH) - 1);
    localparam bit ZR = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] regfile_q [NREGS];
    logic [PEND_WIDTH-1:0] cnt_q     [NREGS];
    logic [PEND_WIDTH-1:0] cnt_d     [NREGS];
    logic                  any_pending_q, any_pending_d;
    logic                  err_underflow_q, err_underflow_d;
    logic                  err_underflow;

    logic [NREGS-1:0]      wr_hit;             // some enabled write targets r
    logic [DATA_WIDTH-1:0] wr_val    [NREGS];  // winning data for r
    logic [RC_W-1:0]       rsv_cnt   [NREGS];  // requested reservations to r
    logic [RC_W-1:0]       rsv_acc   [NREGS];  // accepted reservations to r
    logic [SUM_W-1:0]      req_sum   [NREGS];  // cnt + R - W if all accepted
    logic                  rsv_over;           // some requested r would overflow

    assign err_underflow = err_underflow_q;
    assign any_pending   = any_pending_q;
    assign rsv_full      = rsv_over && !flush;

    // Address 0 is hardwired only when ZERO_REG is set.
    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return ZR && (a == '0);
    endfunction

    // Write decode: scanning ports in ascending order lets the highest
    // enabled port overwrite the others for the same address.
    always_comb begin
        // NOTE: every signal assigned here gets a default before any
        // conditional assignment, so no path can hold a value (no latch).
        wr_hit = '0;
        for (int r = 0; r < NREGS; r++) wr_val[r] = '0;
        for (int i = 0; i < WRITE_PORTS; i++) begin
            if (wr_enable[i] && !is_zero(wr_addr[i])) begin
                wr_hit[wr_addr[i]] = 1'b1;
                wr_val[wr_addr[i]] = wr_data[i];
            end
        end
    end

    // Reservation count per register (duplicates count individually) and
    // the all-or-nothing overflow check.
    always_comb begin
        rsv_over = 1'b0;
        for (int r = 0; r < NREGS; r++) rsv_cnt[r] = '0;
        for (int j = 0; j < RSV_PORTS; j++) begin
            // Reservations to a hardwired zero register are accepted but
            // never counted.
            if (rsv_enable[j] && !is_zero(rsv_addr[j])) begin
                rsv_cnt[rsv_addr[j]] = rsv_cnt[rsv_addr[j]] + RC_W'(1);
            end
        end
        for (int r = 0; r < NREGS; r++) begin
            req_sum[r] = SUM_W'(cnt_q[r]) + SUM_W'(rsv_cnt[r]) - SUM_W'(wr_hit[r]);
            if (rsv_cnt[r] != '0 && req_sum[r] > PEND_MAX) rsv_over = 1'b1;
        end
    end

    // Next-state counters, underflow detection and any_pending.
    always_comb begin
        any_pending_d   = 1'b0;
        err_underflow_d = err_underflow;
        for (int r = 0; r < NREGS; r++) begin
            rsv_acc[r] = rsv_full ? '0 : rsv_cnt[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (cnt_q[r] == '0 && rsv_acc[r] == '0 && wr_hit[r]) begin
                // Write with nothing outstanding: saturate at 0 and flag it.
                cnt_d[r]        = '0;
                err_underflow_d = 1'b1;
            end else begin
                cnt_d[r] = PEND_WIDTH'(SUM_W'(cnt_q[r]) + SUM_W'(rsv_acc[r])
                                       - SUM_W'(wr_hit[r]));
            end
            if (cnt_d[r] != '0) any_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // NOTE: the register array is reset explicitly because reads of
            // never-written registers must return 0; this keeps it in flops.
            for (int r = 0; r < NREGS; r++) begin
                regfile_q[r] <= '0;
                cnt_q[r]     <= '0;
            end
            any_pending_q   <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            for (int r = 0; r < NREGS; r++) begin
                if (wr_hit[r]) regfile_q[r] <= wr_val[r];
                cnt_q[r] <= cnt_d[r];
            end
            any_pending_q   <= any_pending_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // Read ports.
    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_data[p]  = regfile_q[rd_addr[p]];
            rd_ready[p] = (cnt_q[rd_addr[p]] == '0);
`ifdef RFILE_BYPASS_EN
            // A write retiring the last reservation makes the register
            // ready in the same cycle, with its new data.
            if (wr_hit[rd_addr[p]]) begin
                rd_data[p]  = wr_val[rd_addr[p]];
                rd_ready[p] = (cnt_q[rd_addr[p]] == '0) ||
                              (cnt_q[rd_addr[p]] == PEND_WIDTH'(1));
            end
`endif
            if (is_zero(rd_addr[p])) begin
                rd_data[p]  = '0;
                rd_ready[p] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rfile_scb.sv
// -----------------------------------------------------------------------------
// tb_rfile_scb : self-checking bench for rfile_scb (default parameters).
// A behavioural model (arrays of register values and integer pending counts)
// predicts every output each cycle; directed scenarios pin the model with
// literal expectations, then randomized traffic exercises collisions,
// overflow, flush and reset.
// -----------------------------------------------------------------------------
module tb_rfile_scb;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int RP    = 8;
    localparam int WP    = 4;
    localparam int SP    = 2;
    localparam int PW    = 2;
    localparam int ZR    = 1;
    localparam int PMAX  = (1 << PW) - 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [AW-1:0] rd_addr    [RP];
    logic [DW-1:0] rd_data    [RP];
    logic          rd_ready   [RP];
    logic [AW-1:0] wr_addr    [WP];
    logic          wr_enable  [WP];
    logic [DW-1:0] wr_data    [WP];
    logic [AW-1:0] rsv_addr   [SP];
    logic          rsv_enable [SP];
    logic          rsv_full;
    logic          flush;
    logic          any_pending;

    rfile_scb #(
        .NREGS(NREGS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(RP),
        .WRITE_PORTS(WP), .RSV_PORTS(SP), .PEND_WIDTH(PW), .ZERO_REG(ZR)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_addr(wr_addr), .wr_enable(wr_enable), .wr_data(wr_data),
        .rsv_addr(rsv_addr), .rsv_enable(rsv_enable), .rsv_full(rsv_full),
        .flush(flush), .any_pending(any_pending)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [DW-1:0] m_reg [NREGS];
    int            m_cnt [NREGS];
    bit            m_any;
    bit            m_uf;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < WP; i++) begin
            wr_enable[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0;
        end
        for (int j = 0; j < SP; j++) begin
            rsv_enable[j] = 1'b0; rsv_addr[j] = '0;
        end
        flush = 1'b0;
    endtask

    task automatic set_all_rd(input int a);
        for (int p = 0; p < RP; p++) rd_addr[p] = AW'(a);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_reg[r] = '0; m_cnt[r] = 0;
        end
        m_any = 1'b0;
        m_uf  = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied: compares every
    // output against the model, crosses the rising edge, advances the model,
    // and returns at the next falling edge.
    task automatic step();
        int            rc [NREGS];
        bit            wh [NREGS];
        logic [DW-1:0] wv [NREGS];
        bit            full;
        int            a, racc;
        logic [DW-1:0] exp_d;
        bit            exp_r;

        for (int r = 0; r < NREGS; r++) begin
            rc[r] = 0; wh[r] = 1'b0; wv[r] = '0;
        end
        for (int i = 0; i < WP; i++) begin
            a = int'(wr_addr[i]);
            if (wr_enable[i] && !(ZR == 1 && a == 0)) begin
                wh[a] = 1'b1; wv[a] = wr_data[i];
            end
        end
        for (int j = 0; j < SP; j++) begin
            a = int'(rsv_addr[j]);
            if (rsv_enable[j] && !(ZR == 1 && a == 0)) rc[a]++;
        end
        full = 1'b0;
        if (!flush) begin
            for (int r = 0; r < NREGS; r++)
                if (rc[r] > 0 && m_cnt[r] + rc[r] - int'(wh[r]) > PMAX) full = 1'b1;
        end

        #1;
        for (int p = 0; p < RP; p++) begin
            a     = int'(rd_addr[p]);
            exp_d = m_reg[a];
            exp_r = (m_cnt[a] == 0);
`ifdef RFILE_BYPASS_EN
            if (wh[a]) begin
                exp_d = wv[a];
                exp_r = (m_cnt[a] == 0) || (m_cnt[a] == 1);
            end
`endif
            if (ZR == 1 && a == 0) begin
                exp_d = '0; exp_r = 1'b1;
            end
            check($sformatf("rd_data[%0d] addr %0d", p, a), 64'(rd_data[p]), 64'(exp_d));
            check($sformatf("rd_ready[%0d] addr %0d", p, a), 64'(rd_ready[p]), 64'(exp_r));
        end
        check("rsv_full", 64'(rsv_full), 64'(full));
        check("any_pending", 64'(any_pending), 64'(m_any));
        check("err_underflow", 64'(dut.err_underflow), 64'(m_uf));

        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wh[r]) m_reg[r] = wv[r];
                if (flush) begin
                    m_cnt[r] = 0;
                end else begin
                    racc = full ? 0 : rc[r];
                    if (m_cnt[r] == 0 && racc == 0 && wh[r]) m_uf = 1'b1;
                    else m_cnt[r] = m_cnt[r] + racc - int'(wh[r]);
                end
            end
            m_any = 1'b0;
            for (int r = 0; r < NREGS; r++) if (m_cnt[r] != 0) m_any = 1'b1;
        end
        @(negedge clock);
    endtask

    initial begin
        clear_inputs();
        set_all_rd(0);
        reset_n = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Reset then read address 5 on all ports.
        set_all_rd(5);
        #1;
        check("reset rd_data r5", 64'(rd_data[3]), 64'h0);
        check("reset rd_ready r5", 64'(rd_ready[3]), 64'h1);
        check("reset any_pending", 64'(any_pending), 64'h0);
        step();

        // Reserve r7, write it two cycles later.
        rsv_enable[0] = 1'b1; rsv_addr[0] = 7;
        step();
        clear_inputs();
        set_all_rd(7);
        #1;
        check("r7 reserved ready", 64'(rd_ready[0]), 64'h0);
        check("r7 reserved any_pending", 64'(any_pending), 64'h1);
        step();
        wr_enable[1] = 1'b1; wr_addr[1] = 7; wr_data[1] = 32'hDEADBEEF;
        #1;
`ifdef RFILE_BYPASS_EN
        check("r7 write-cycle ready", 64'(rd_ready[0]), 64'h1);
        check("r7 write-cycle data", 64'(rd_data[0]), 64'hDEADBEEF);
`else
        check("r7 write-cycle ready", 64'(rd_ready[0]), 64'h0);
        check("r7 write-cycle data", 64'(rd_data[0]), 64'h0);
`endif
        step();
        clear_inputs();
        #1;
        check("r7 after write ready", 64'(rd_ready[0]), 64'h1);
        check("r7 after write data", 64'(rd_data[0]), 64'hDEADBEEF);
        step();

        // Two reservations to r4, then ports 0 and 3 both write r4.
        rsv_enable[0] = 1'b1; rsv_addr[0] = 4;
        rsv_enable[1] = 1'b1; rsv_addr[1] = 4;
        step();
        clear_inputs();
        check("r4 count after dual reserve", 64'(dut.cnt_q[4]), 64'h2);
        wr_enable[0] = 1'b1; wr_addr[0] = 4; wr_data[0] = 32'h11;
        wr_enable[3] = 1'b1; wr_addr[3] = 4; wr_data[3] = 32'h33;
        set_all_rd(4);
        step();
        clear_inputs();
        #1;
        check("r4 highest port wins", 64'(rd_data[2]), 64'h33);
        check("r4 count dropped by one", 64'(dut.cnt_q[4]), 64'h1);
        check("model r4 count", 64'(m_cnt[4]), 64'h1);
        step();

        // Saturate r9 at three, then a fourth request.
        rsv_enable[0] = 1'b1; rsv_addr[0] = 9;
        rsv_enable[1] = 1'b1; rsv_addr[1] = 9;
        step();
        rsv_enable[1] = 1'b0;
        step();
        set_all_rd(9);
        #1;
        check("r9 fourth reserve rsv_full", 64'(rsv_full), 64'h1);
        step();
        check("r9 count stays 3", 64'(dut.cnt_q[9]), 64'h3);
        wr_enable[2] = 1'b1; wr_addr[2] = 9; wr_data[2] = 32'h99;
        #1;
        check("r9 reserve+write rsv_full", 64'(rsv_full), 64'h0);
        step();
        clear_inputs();
        check("r9 count still 3", 64'(dut.cnt_q[9]), 64'h3);
        check("model r9 count", 64'(m_cnt[9]), 64'h3);

        // Reserve r2 and r3, then flush with a write to r2. A reservation to
        // the saturated r9 in the flush cycle must not raise rsv_full.
        rsv_enable[0] = 1'b1; rsv_addr[0] = 2;
        rsv_enable[1] = 1'b1; rsv_addr[1] = 3;
        step();
        clear_inputs();
        flush = 1'b1;
        wr_enable[0] = 1'b1; wr_addr[0] = 2; wr_data[0] = 32'h5;
        rsv_enable[0] = 1'b1; rsv_addr[0] = 9;
        rsv_enable[1] = 1'b1; rsv_addr[1] = 9;
        #1;
        check("flush forces rsv_full 0", 64'(rsv_full), 64'h0);
        step();
        clear_inputs();
        set_all_rd(2);
        rd_addr[1] = 3;
        #1;
        check("flush r2 count", 64'(dut.cnt_q[2]), 64'h0);
        check("flush r3 count", 64'(dut.cnt_q[3]), 64'h0);
        check("flush r2 data", 64'(rd_data[0]), 64'h5);
        check("flush any_pending", 64'(any_pending), 64'h0);
        check("err_underflow still clear", 64'(dut.err_underflow), 64'h0);
        step();

        // Zero register: write and reserve r0.
        wr_enable[3] = 1'b1; wr_addr[3] = 0; wr_data[3] = 32'hFFFF;
        rsv_enable[0] = 1'b1; rsv_addr[0] = 0;
        set_all_rd(0);
        #1;
        check("r0 write-cycle data", 64'(rd_data[5]), 64'h0);
        step();
        clear_inputs();
        #1;
        check("r0 data", 64'(rd_data[5]), 64'h0);
        check("r0 ready", 64'(rd_ready[5]), 64'h1);
        check("r0 any_pending", 64'(any_pending), 64'h0);
        step();

        // Write with nothing pending sets the sticky underflow flag.
        wr_enable[0] = 1'b1; wr_addr[0] = 10; wr_data[0] = 32'hA5A5;
        step();
        clear_inputs();
        check("underflow flag set", 64'(dut.err_underflow), 64'h1);
        check("underflow r10 count", 64'(dut.cnt_q[10]), 64'h0);
        step();

        // Randomized traffic on a narrow address window to force collisions.
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 249) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < WP; i++) begin
                wr_enable[i] = ($urandom_range(0, 9) < 3);
                wr_addr[i]   = AW'($urandom_range(0, 7));
                wr_data[i]   = $urandom;
            end
            for (int j = 0; j < SP; j++) begin
                rsv_enable[j] = ($urandom_range(0, 9) < 5);
                rsv_addr[j]   = AW'($urandom_range(0, 7));
            end
            for (int p = 0; p < RP; p++)
                rd_addr[p] = ($urandom_range(0, 7) == 0) ? AW'($urandom) :
                                                           AW'($urandom_range(0, 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
